// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch/jump
// flushes, multi-cycle data-memory freezes and a sticky memory-timeout error.
module pipe_hazard_sequencer #(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             id_ex_memread_i,
   input  logic [REG_W-1:0] id_ex_rt_i,
   input  logic [REG_W-1:0] if_id_rs_i,
   input  logic [REG_W-1:0] if_id_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             ctrl_bubble_o,
   output logic             pipe_hold_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   // state   | meaning
   // IDLE    | pipe frozen, waiting for start_i
   // RUN     | normal issue; hazards resolved combinationally
   // MEMWAIT | data memory access outstanding, pipe frozen
   // ERR     | memory timeout; frozen until reset
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_MEMWAIT = 2'd2;
   localparam logic [1:0] S_ERR     = 2'd3;

   localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use;
   logic redirect;

   assign load_use = id_ex_memread_i && (id_ex_rt_i != '0) &&
                     ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
   assign redirect = branch_taken_i || jump_i;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      err_d         = err_q;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b0;
      ctrl_bubble_o = 1'b0;
      pipe_hold_o   = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_RUN;
         end
         S_RUN, S_MEMWAIT: begin
            if ((state_q == S_RUN) && dmem_req_i && !dmem_ack_i) begin
               state_d = S_MEMWAIT;
               wait_d  = 8'd1;
            end else if ((state_q == S_MEMWAIT) && !dmem_ack_i) begin
               wait_d = wait_q + 8'd1;
               if (wait_q == WAIT_LIMIT) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end else begin
               // Released cycle: the load-use check still applies, and a
               // redirect is held back while the bubble is being inserted.
               state_d     = S_RUN;
               wait_d      = 8'd0;
               pipe_hold_o = 1'b0;
               if (load_use) begin
                  ctrl_bubble_o = 1'b1;
               end else begin
                  pc_write_o    = 1'b1;
                  if_id_write_o = 1'b1;
                  if_id_flush_o = redirect;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      if (((state_q == S_RUN) || (state_q == S_MEMWAIT)) && !pc_write_o &&
          (stall_q != CNT_MAX))
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end

   assign mem_err_o   = err_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer; a second instance with a 4-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_pipe_hazard_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       id_ex_memread_i;
   logic [4:0] id_ex_rt_i, if_id_rs_i, if_id_rt_i;
   logic       branch_taken_i, jump_i, dmem_req_i, dmem_ack_i;

   logic        pc_write_o, if_id_write_o, if_id_flush_o, ctrl_bubble_o, pipe_hold_o, mem_err_o;
   logic [15:0] stall_cnt_o;
   logic        s_pc_write, s_if_id_write, s_flush, s_bubble, s_hold, s_err;
   logic [3:0]  s_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   pipe_hazard_sequencer #(.REG_W(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
      .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i),
      .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
      .if_id_flush_o(if_id_flush_o), .ctrl_bubble_o(ctrl_bubble_o),
      .pipe_hold_o(pipe_hold_o), .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o)
   );

   pipe_hazard_sequencer #(.REG_W(5), .MEM_TIMEOUT(16), .CNT_W(4)) u_sat (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
      .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i),
      .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(s_pc_write), .if_id_write_o(s_if_id_write),
      .if_id_flush_o(s_flush), .ctrl_bubble_o(s_bubble),
      .pipe_hold_o(s_hold), .mem_err_o(s_err), .stall_cnt_o(s_stall_cnt)
   );

   // Drive point is 1 time unit after the rising edge; checks follow a further #2.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      start_i = 0; id_ex_memread_i = 0; id_ex_rt_i = 0; if_id_rs_i = 0; if_id_rt_i = 0;
      branch_taken_i = 0; jump_i = 0; dmem_req_i = 0; dmem_ack_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 0;
      tick();
      tick();
      rst_i = 1;
   endtask

   task automatic start_run();
      start_i = 1;
      tick();
      start_i = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      n_tests++;
      if ({pc_write_o, if_id_write_o, if_id_flush_o, ctrl_bubble_o, pipe_hold_o} !== 5'b00001)
         begin n_fail++; $display("FAIL reset_outputs got=%b exp=00001",
            {pc_write_o, if_id_write_o, if_id_flush_o, ctrl_bubble_o, pipe_hold_o}); end
      n_tests++;
      if (stall_cnt_o !== 16'd0 || mem_err_o !== 1'b0)
         begin n_fail++; $display("FAIL reset_regs cnt=%0d err=%b exp 0/0", stall_cnt_o, mem_err_o); end
      tick();
      n_tests++;
      if (pc_write_o !== 1'b0 || pipe_hold_o !== 1'b1)
         begin n_fail++; $display("FAIL idle_holds pc=%b hold=%b exp 0/1", pc_write_o, pipe_hold_o); end
      start_run();
      #2;
      n_tests++;
      if (pc_write_o !== 1'b1 || if_id_write_o !== 1'b1 || pipe_hold_o !== 1'b0 || stall_cnt_o !== 16'd0)
         begin n_fail++; $display("FAIL first_run pc=%b ifid=%b hold=%b cnt=%0d exp 1/1/0/0",
            pc_write_o, if_id_write_o, pipe_hold_o, stall_cnt_o); end
   endtask

   task automatic test_load_use();
      tick();
      id_ex_memread_i = 1; id_ex_rt_i = 8; if_id_rs_i = 8; if_id_rt_i = 3;
      #2;
      n_tests++;
      if (pc_write_o !== 1'b0 || if_id_write_o !== 1'b0 || ctrl_bubble_o !== 1'b1 || pipe_hold_o !== 1'b0)
         begin n_fail++; $display("FAIL load_use pc=%b ifid=%b bub=%b hold=%b exp 0/0/1/0",
            pc_write_o, if_id_write_o, ctrl_bubble_o, pipe_hold_o); end
      tick();
      clear_inputs();
      #2;
      n_tests++;
      if (pc_write_o !== 1'b1 || stall_cnt_o !== 16'd1)
         begin n_fail++; $display("FAIL load_use_after pc=%b cnt=%0d exp 1/1", pc_write_o, stall_cnt_o); end
      tick();
      id_ex_memread_i = 1; id_ex_rt_i = 0; if_id_rs_i = 0; if_id_rt_i = 0;
      #2;
      n_tests++;
      if (pc_write_o !== 1'b1 || ctrl_bubble_o !== 1'b0)
         begin n_fail++; $display("FAIL reg0_no_hazard pc=%b bub=%b exp 1/0", pc_write_o, ctrl_bubble_o); end
      tick();
      clear_inputs();
      id_ex_memread_i = 1; id_ex_rt_i = 12; if_id_rs_i = 4; if_id_rt_i = 12;
      #2;
      n_tests++;
      if (ctrl_bubble_o !== 1'b1 || pc_write_o !== 1'b0)
         begin n_fail++; $display("FAIL load_use_rt bub=%b pc=%b exp 1/0", ctrl_bubble_o, pc_write_o); end
      tick();
      clear_inputs();
      #2;
      n_tests++;
      if (stall_cnt_o !== 16'd2)
         begin n_fail++; $display("FAIL load_use_cnt got=%0d exp=2", stall_cnt_o); end
   endtask

   task automatic test_load_use_branch();
      tick();
      id_ex_memread_i = 1; id_ex_rt_i = 5; if_id_rs_i = 5; branch_taken_i = 1;
      #2;
      n_tests++;
      if (ctrl_bubble_o !== 1'b1 || if_id_flush_o !== 1'b0 || pc_write_o !== 1'b0)
         begin n_fail++; $display("FAIL lu_branch bub=%b flush=%b pc=%b exp 1/0/0",
            ctrl_bubble_o, if_id_flush_o, pc_write_o); end
      tick();
      id_ex_memread_i = 0;
      #2;
      n_tests++;
      if (if_id_flush_o !== 1'b1 || pc_write_o !== 1'b1 || stall_cnt_o !== 16'd3)
         begin n_fail++; $display("FAIL branch_replay flush=%b pc=%b cnt=%0d exp 1/1/3",
            if_id_flush_o, pc_write_o, stall_cnt_o); end
      tick();
      clear_inputs();
      jump_i = 1;
      #2;
      n_tests++;
      if (if_id_flush_o !== 1'b1 || if_id_write_o !== 1'b1)
         begin n_fail++; $display("FAIL jump_flush flush=%b ifid=%b exp 1/1", if_id_flush_o, if_id_write_o); end
      tick();
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      dmem_req_i = 1; dmem_ack_i = 0;
      for (int c = 1; c <= 3; c++) begin
         #2;
         n_tests++;
         if (pipe_hold_o !== 1'b1 || pc_write_o !== 1'b0)
            begin n_fail++; $display("FAIL mem_hold_c%0d hold=%b pc=%b exp 1/0", c, pipe_hold_o, pc_write_o); end
         tick();
      end
      dmem_ack_i = 1;
      #2;
      n_tests++;
      if (pipe_hold_o !== 1'b0 || pc_write_o !== 1'b1)
         begin n_fail++; $display("FAIL mem_release hold=%b pc=%b exp 0/1", pipe_hold_o, pc_write_o); end
      tick();
      #2;
      n_tests++;
      if (pipe_hold_o !== 1'b0 || stall_cnt_o !== 16'd6)
         begin n_fail++; $display("FAIL zero_wait hold=%b cnt=%0d exp 0/6", pipe_hold_o, stall_cnt_o); end
      tick();
      dmem_ack_i = 0;
      tick();
      dmem_ack_i = 1; id_ex_memread_i = 1; id_ex_rt_i = 9; if_id_rs_i = 9;
      #2;
      n_tests++;
      if (ctrl_bubble_o !== 1'b1 || pipe_hold_o !== 1'b0 || pc_write_o !== 1'b0)
         begin n_fail++; $display("FAIL ack_load_use bub=%b hold=%b pc=%b exp 1/0/0",
            ctrl_bubble_o, pipe_hold_o, pc_write_o); end
      tick();
      clear_inputs();
      #2;
      n_tests++;
      if (pc_write_o !== 1'b1 || stall_cnt_o !== 16'd8)
         begin n_fail++; $display("FAIL ack_lu_after pc=%b cnt=%0d exp 1/8", pc_write_o, stall_cnt_o); end
   endtask

   task automatic test_timeout();
      dmem_req_i = 1; dmem_ack_i = 0;
      repeat (15) tick();
      #2;
      n_tests++;
      if (mem_err_o !== 1'b0 || pipe_hold_o !== 1'b1)
         begin n_fail++; $display("FAIL pre_timeout err=%b hold=%b exp 0/1", mem_err_o, pipe_hold_o); end
      tick();
      #2;
      n_tests++;
      if (mem_err_o !== 1'b1 || stall_cnt_o !== 16'd24)
         begin n_fail++; $display("FAIL timeout err=%b cnt=%0d exp 1/24", mem_err_o, stall_cnt_o); end
      dmem_ack_i = 1; start_i = 1;
      tick();
      tick();
      #2;
      n_tests++;
      if ({pc_write_o, if_id_write_o, pipe_hold_o, mem_err_o} !== 4'b0011 || stall_cnt_o !== 16'd24)
         begin n_fail++; $display("FAIL err_frozen got=%b cnt=%0d exp 0011/24",
            {pc_write_o, if_id_write_o, pipe_hold_o, mem_err_o}, stall_cnt_o); end
      rst_i = 0;
      #1;
      n_tests++;
      if (mem_err_o !== 1'b0 || stall_cnt_o !== 16'd0 || pipe_hold_o !== 1'b1)
         begin n_fail++; $display("FAIL async_reset err=%b cnt=%0d hold=%b exp 0/0/1",
            mem_err_o, stall_cnt_o, pipe_hold_o); end
      tick();
   endtask

   task automatic test_ack_at_limit();
      do_reset();
      start_run();
      dmem_req_i = 1; dmem_ack_i = 0;
      repeat (15) tick();
      dmem_ack_i = 1;
      #2;
      n_tests++;
      if (pc_write_o !== 1'b1 || pipe_hold_o !== 1'b0)
         begin n_fail++; $display("FAIL ack_limit pc=%b hold=%b exp 1/0", pc_write_o, pipe_hold_o); end
      tick();
      clear_inputs();
      #2;
      n_tests++;
      if (mem_err_o !== 1'b0 || pc_write_o !== 1'b1 || stall_cnt_o !== 16'd15)
         begin n_fail++; $display("FAIL ack_limit_after err=%b pc=%b cnt=%0d exp 0/1/15",
            mem_err_o, pc_write_o, stall_cnt_o); end
   endtask

   task automatic test_saturation();
      do_reset();
      start_run();
      id_ex_memread_i = 1; id_ex_rt_i = 17; if_id_rs_i = 17;
      repeat (20) tick();
      #2;
      n_tests++;
      if (s_stall_cnt !== 4'd15 || stall_cnt_o !== 16'd20)
         begin n_fail++; $display("FAIL saturation sat=%0d main=%0d exp 15/20", s_stall_cnt, stall_cnt_o); end
      rst_i = 0;
      #1;
      n_tests++;
      if (ctrl_bubble_o !== 1'b0 || pc_write_o !== 1'b0 || pipe_hold_o !== 1'b1 || s_stall_cnt !== 4'd0)
         begin n_fail++; $display("FAIL reset_mid_stall bub=%b pc=%b hold=%b sat=%0d exp 0/0/1/0",
            ctrl_bubble_o, pc_write_o, pipe_hold_o, s_stall_cnt); end
      tick();
      rst_i = 1;
      clear_inputs();
   endtask

   initial begin
      rst_i = 0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_load_use_branch();
      test_mem_wait();
      test_timeout();
      test_ack_at_limit();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
